// File: rtl/map_loader.sv
// map_loader: unpacks a framed byte stream into one map-cell RAM write per cycle.
// Cells are written row-fastest so the linear index {col,row} matches ROM load order.
module map_loader #(
  parameter int         COLBITS   = 4,
  parameter int         ROWBITS   = 4,
  parameter int         BITS      = 2,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               abort,
  output logic               wr_en,
  output logic [ROWBITS-1:0] wr_row,
  output logic [COLBITS-1:0] wr_col,
  output logic [BITS-1:0]    wr_val,
  output logic               busy,
  output logic               done
);

  localparam int CPB = 8 / BITS;
  localparam int AW  = COLBITS + ROWBITS;
  localparam int CW  = $clog2(CPB + 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    EMIT
  } state_t;

  state_t             r_state;
  logic               r_in_ready;
  logic               r_wr_en;
  logic [ROWBITS-1:0] r_row;
  logic [COLBITS-1:0] r_col;
  logic [BITS-1:0]    r_val;
  logic               r_busy;
  logic               r_done;
  logic [7:0]         r_shift;
  logic [CW-1:0]      r_cnt;
  logic [AW-1:0]      r_addr;
  logic               r_last;

  state_t             w_state_nxt;
  logic               w_wr_en;
  logic [ROWBITS-1:0] w_row;
  logic [COLBITS-1:0] w_col;
  logic [BITS-1:0]    w_val;
  logic               w_busy;
  logic               w_done;
  logic [7:0]         w_shift;
  logic [CW-1:0]      w_cnt;
  logic [AW-1:0]      w_addr;
  logic               w_last;

  logic w_acc;
  logic w_sync;
  logic w_load;
  logic w_step;
  logic w_end;

  // abort masks acceptance, so all event terms below are mutually exclusive
  assign w_acc  = in_valid & r_in_ready & ~abort;
  assign w_sync = (r_state == IDLE) & w_acc & (in_data == SYNC_BYTE);
  assign w_load = (r_state == RECV) & w_acc;
  assign w_step = (r_state == EMIT) & ~abort & (r_cnt != CW'(CPB));
  assign w_end  = (r_state == EMIT) & ~abort & (r_cnt == CW'(CPB));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_in_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
      r_val      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_last     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != EMIT);
      r_wr_en    <= w_wr_en;
      r_row      <= w_row;
      r_col      <= w_col;
      r_val      <= w_val;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_shift    <= w_shift;
      r_cnt      <= w_cnt;
      r_addr     <= w_addr;
      r_last     <= w_last;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      abort:   w_state_nxt = IDLE;
      w_sync:  w_state_nxt = RECV;
      w_load:  w_state_nxt = EMIT;
      w_end:   w_state_nxt = r_last ? IDLE : RECV;
      default: w_state_nxt = r_state;
    endcase
  end

  always_comb begin
    w_wr_en = 1'b0;
    w_row   = r_row;
    w_col   = r_col;
    w_val   = r_val;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_shift = r_shift;
    w_cnt   = r_cnt;
    w_addr  = r_addr;
    w_last  = r_last;
    unique case (1'b1)
      abort: begin
        w_busy  = 1'b0;
        w_shift = '0;
        w_cnt   = '0;
        w_addr  = '0;
        w_last  = 1'b0;
      end
      w_sync: w_busy = 1'b1;
      // first cell comes straight from the bus so it lands the cycle after acceptance
      w_load: begin
        w_val   = in_data[BITS-1:0];
        w_shift = in_data >> BITS;
        w_cnt   = CW'(1);
      end
      w_step: begin
        w_val   = r_shift[BITS-1:0];
        w_shift = r_shift >> BITS;
        w_cnt   = r_cnt + CW'(1);
      end
      w_end: begin
        w_cnt = '0;
        if (r_last) begin
          w_busy = 1'b0;
          w_done = 1'b1;
          w_last = 1'b0;
        end
      end
      default: ;
    endcase
    if (w_load || w_step) begin
      w_wr_en = 1'b1;
      w_row   = r_addr[ROWBITS-1:0];
      w_col   = r_addr[AW-1:ROWBITS];
      w_addr  = r_addr + AW'(1);
      w_last  = (r_addr == '1);
    end
  end

  assign in_ready = r_in_ready;
  assign wr_en    = r_wr_en;
  assign wr_row   = r_row;
  assign wr_col   = r_col;
  assign wr_val   = r_val;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: doc/map_loader.md
Name: map_loader

Overview:
Writer-side counterpart to the map lookup ROM. It receives a byte stream carrying a complete game map, using a valid/ready handshake from a host link (SPI/UART front-end). It unpacks each byte into map cells and issues one cell write per cycle to the map RAM's write port. It lets the map be replaced at runtime instead of being fixed at synthesis.

Parameters:
COLBITS, 4, column address width; COLCOUNT = 2^COLBITS.
ROWBITS, 4, row address width; ROWCOUNT = 2^ROWBITS.
BITS, 2, bits per map cell; legal values 1, 2, 4, 8; CPB (cells per byte) = 8/BITS.
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
clk  input  1  system clock, all state on rising edge.
reset_n  input  1  asynchronous active-low reset.
in_data  input  8  stream byte.
in_valid  input  1  in_data valid.
in_ready  output  1  loader can accept a byte this cycle.
abort  input  1  synchronous frame cancel.
wr_en  output  1  cell write strobe, one cell per asserted cycle.
wr_row  output  ROWBITS  cell row.
wr_col  output  COLBITS  cell column.
wr_val  output  BITS  cell value.
busy  output  1  frame in progress (sync seen, done not yet pulsed).
done  output  1  one-cycle pulse after the last cell write.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE. in_ready=0 while reset is asserted. wr_en=0, wr_row=0, wr_col=0, wr_val=0, busy=0, done=0. Shift register and unpack counter are cleared.
- All outputs are registered. in_ready is a function of state only: 1 in IDLE and RECV, 0 in EMIT.
- A byte is accepted only on a cycle where in_valid and in_ready are both 1.
- IDLE: an accepted byte equal to SYNC_BYTE moves to RECV and sets busy=1. Any other accepted byte is discarded with no write.
- RECV: an accepted byte is latched into the shift register and the state moves to EMIT.
- EMIT: lasts exactly CPB cycles, starting the cycle after acceptance.
  - Each cycle drives wr_en=1 and wr_val = shift[BITS-1:0], LSB-first, then shifts right by BITS.
  - After CPB cells it returns to RECV.
- Latency: a byte accepted at edge N gives cell writes visible in cycles N+1 .. N+CPB. Peak throughput is one byte per CPB+1 cycles.
- Address order: row increments fastest, then column, so linear index = {col,row}, matching ROM load order.
  - Address advances after each write.
  - The first write of a frame is row 0, col 0.
  - The last write is row MAXROW, col MAXCOL.
  - wr_row/wr_col hold their last value while wr_en=0.
- Frame end: the cycle after the final write (row MAXROW, col MAXCOL), done=1 for one cycle, busy=0, and the state goes to IDLE. Counters wrap to 0.
  - SYNC_BYTE appearing inside frame data is treated as data.
- A frame is exactly COLCOUNT*ROWCOUNT/CPB data bytes (64 for the defaults).
- abort=1 in any state: at the next edge, go to IDLE, wr_en=0, busy=0, counters and shift register cleared, no done pulse. A byte offered in the same cycle is not accepted (in_ready is treated as 0 that cycle).
- abort has priority over acceptance and over done.
- Reset asserted mid-frame: outputs go immediately to reset values. Any partial map written stays in the RAM. There is no rollback.
- in_valid may drop at any time in RECV. The loader waits indefinitely, with no timeout.

Test Plan:
1. Assert reset_n=0 mid-simulation with arbitrary stimulus -> all outputs 0 immediately. After release, in_ready=1, busy=0.
2. Send 0x00, 0x3C, then 0xA5 in IDLE -> no wr_en for the first two. busy rises the cycle after 0xA5 is accepted.
3. Send 0xA5 then 64 bytes of 0xE4 (defaults) -> 256 writes. Writes 0..3 are (row0,col0,0), (row1,col0,1), (row2,col0,2), (row3,col0,3). The final write is (row15,col15,3). done=1 for exactly one cycle after it, then busy=0.
4. Repeat scenario 3 with in_valid randomly deasserted -> in_ready=0 for exactly 4 cycles after each acceptance. No byte lost or duplicated. Write sequence identical to scenario 3.
5. Abort after 10 data bytes, then send 0xA5 + 64 bytes -> wr_en=0 the cycle after abort, no done. The new frame starts at row0,col0 and completes with done.
6. Pulse reset_n low during EMIT of byte 30 -> wr_en drops asynchronously, busy=0. A subsequent full frame loads correctly.
